// File: rtl/ndn_pkg.sv
// Shared NDN datapath widths, serializer frame lengths and the TX scheduler state type.
package ndn_pkg;
  localparam int META_W             = 8;
  localparam int PREFIX_W           = 64;
  localparam int DATA_W             = 256;
  localparam int TYPE_BIT           = 6;
  localparam int INTEREST_FRAME_LEN = 73;
  localparam int DATA_FRAME_LEN     = 329;

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} tx_sched_state_t;
endpackage

// File: rtl/ndn_tx_scheduler_if.sv
// Request side (per-source packets) and TX side (serializer launch) of the scheduler.
interface ndn_tx_scheduler_if #(parameter int NUM_REQ = 4);
  import ndn_pkg::*;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*META_W-1:0]   req_meta;
  logic [NUM_REQ*PREFIX_W-1:0] req_prefix;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic                        tx_valid;
  logic [META_W-1:0]           tx_meta;
  logic [PREFIX_W-1:0]         tx_prefix;
  logic [DATA_W-1:0]           tx_data;

  modport master (
    input  req_valid, req_meta, req_prefix, req_data,
    output req_ready, tx_valid, tx_meta, tx_prefix, tx_data
  );

  modport slave (
    output req_valid, req_meta, req_prefix, req_data,
    input  req_ready, tx_valid, tx_meta, tx_prefix, tx_data
  );
endinterface

// File: rtl/ndn_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module ndn_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  logic [IDX_W-1:0] cand;

  // Scanning from the farthest offset down lets the nearest hit overwrite.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = any && (idx == IDX_W'(gi));
  end
endmodule

// File: rtl/ndn_tx_scheduler.sv
// Round-robin sharing of one SPI serializer; holds off for frame length plus guard gap
// because the serializer reports no completion.
module ndn_tx_scheduler
  import ndn_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int GAP_CYCLES = 2,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  ndn_tx_scheduler_if.master  bus,
  output logic                busy,
  output logic [IDX_W-1:0]    grant_id,
  output logic [CNT_W-1:0]    frames_sent
);
  localparam int HOLD_MAX = DATA_FRAME_LEN + GAP_CYCLES - 1;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  tx_sched_state_t      state_reg, state_next;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [HOLD_W-1:0]    hold_cnt_reg;
  logic [CNT_W-1:0]     frames_reg;
  logic [IDX_W-1:0]     grant_id_reg;
  logic [META_W-1:0]    tx_meta_reg;
  logic [PREFIX_W-1:0]  tx_prefix_reg;
  logic [DATA_W-1:0]    tx_data_reg;
  logic [NUM_REQ-1:0]   req_ready_next;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 accept;

  ndn_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // rst is in the term so ready is low for the whole reset pulse, not just after the edge.
  assign accept = (state_reg == IDLE) && enable && pick_any && !rst;

  always_comb begin
    state_next     = state_reg;
    req_ready_next = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          req_ready_next = pick_grant;
          state_next     = LAUNCH;
        end
      end
      LAUNCH:  state_next = HOLD;
      HOLD:    if (hold_cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      hold_cnt_reg  <= '0;
      frames_reg    <= '0;
      grant_id_reg  <= '0;
      tx_meta_reg   <= '0;
      tx_prefix_reg <= '0;
      tx_data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        tx_meta_reg   <= bus.req_meta[int'(pick_idx)*META_W +: META_W];
        tx_prefix_reg <= bus.req_prefix[int'(pick_idx)*PREFIX_W +: PREFIX_W];
        tx_data_reg   <= bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
        grant_id_reg  <= pick_idx;
        rr_ptr_reg    <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
      end
      if (state_reg == LAUNCH) begin
        frames_reg   <= frames_reg + 1'b1;
        hold_cnt_reg <= tx_meta_reg[TYPE_BIT] ? HOLD_W'(INTEREST_FRAME_LEN + GAP_CYCLES - 1)
                                              : HOLD_W'(DATA_FRAME_LEN + GAP_CYCLES - 1);
      end else if (state_reg == HOLD && hold_cnt_reg != '0) begin
        hold_cnt_reg <= hold_cnt_reg - 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready_next;
  assign bus.tx_valid  = (state_reg == LAUNCH);
  assign bus.tx_meta   = tx_meta_reg;
  assign bus.tx_prefix = tx_prefix_reg;
  assign bus.tx_data   = tx_data_reg;
  assign busy          = (state_reg != IDLE);
  assign grant_id      = grant_id_reg;
  assign frames_sent   = frames_reg;
endmodule
